// File: rtl/call_stack.sv
// call_stack: hardware return-address stack for call/return instructions.
// Pushes/pops PC values, presents a registered top-of-stack, count and flags.
// Optional feature macro: CALL_STACK_ERROR_FLAGS_EN enables sticky
// overflow/underflow flags and the in_clear_err input.
module call_stack #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_push_en,
  input  logic                     in_pop_en,
  input  logic                     in_clear_err,
  input  logic [WIDTH-1:0]         in_data,
  output logic [WIDTH-1:0]         out_data,
  output logic [3:0]               out_flags,
  output logic [$clog2(DEPTH):0]   out_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    sp;
  logic [CW-1:0]    sp_next;
  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] top_next;
  logic             empty_q;
  logic             full_q;
  logic             ovf;
  logic             udf;
  logic             empty_c;
  logic             full_c;
  logic             wr_en_c;
  logic [AW-1:0]    wr_addr_c;
  logic             ovf_evt_c;
  logic             udf_evt_c;

  assign empty_c = (sp == '0);
  assign full_c  = (sp == CW'(DEPTH));

  // Decode the strobes into the next pointer, next top and the memory write.
  always_comb begin
    sp_next   = sp;
    top_next  = top;
    wr_en_c   = 1'b0;
    wr_addr_c = '0;
    ovf_evt_c = 1'b0;
    udf_evt_c = 1'b0;
    if (in_push_en && in_pop_en && !empty_c) begin
      // Replace the top entry in place; depth unchanged.
      wr_en_c   = 1'b1;
      wr_addr_c = AW'(sp - CW'(1));
      top_next  = in_data;
    end else if (in_push_en) begin
      // Plain push (also push+pop on an empty stack).
      if (!full_c) begin
        wr_en_c   = 1'b1;
        wr_addr_c = AW'(sp);
        sp_next   = sp + CW'(1);
        top_next  = in_data;
      end else begin
        ovf_evt_c = 1'b1;
      end
    end else if (in_pop_en) begin
      if (!empty_c) begin
        sp_next  = sp - CW'(1);
        top_next = (sp == CW'(1)) ? '0 : mem[AW'(sp - CW'(2))];
      end else begin
        udf_evt_c = 1'b1;
      end
    end
  end

  // Pointer, top-of-stack and occupancy flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp      <= '0;
      top     <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      sp      <= sp_next;
      top     <= top_next;
      empty_q <= (sp_next == '0);
      full_q  <= (sp_next == CW'(DEPTH));
    end
  end

  // Entry storage; contents survive reset, only the pointer is cleared.
  always_ff @(posedge clk) begin
    if (!reset && wr_en_c) begin
      mem[wr_addr_c] <= in_data;
    end
  end

`ifdef CALL_STACK_ERROR_FLAGS_EN
  // Sticky error flags; a new error beats a concurrent clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      ovf <= ovf_evt_c | (ovf & ~in_clear_err);
      udf <= udf_evt_c | (udf & ~in_clear_err);
    end
  end
`else
  logic unused_err;
  assign unused_err = in_clear_err ^ ovf_evt_c ^ udf_evt_c;
  assign ovf = 1'b0;
  assign udf = 1'b0;
`endif

  assign out_data  = top;
  assign out_count = sp;
  assign out_flags = {udf, ovf, full_q, empty_q};

endmodule

// File: tb/tb_call_stack.sv
// tb_call_stack: directed plus randomized checks of call_stack against a
// queue-based stack model.
module tb_call_stack;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned WIDTH = 9;
`ifdef CALL_STACK_ERROR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_push_en = 1'b0;
  logic             in_pop_en = 1'b0;
  logic             in_clear_err = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic [WIDTH-1:0] out_data;
  logic [3:0]       out_flags;
  logic [4:0]       out_count;

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  logic [WIDTH-1:0] q[$];
  bit m_ovf = 1'b0;
  bit m_udf = 1'b0;
  bit model_valid = 1'b0;

  call_stack #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .in_push_en(in_push_en), .in_pop_en(in_pop_en),
    .in_clear_err(in_clear_err), .in_data(in_data), .out_data(out_data),
    .out_flags(out_flags), .out_count(out_count)
  );

  always #5 clk = ~clk;

  // Reference model: update on every rising edge from the sampled strobes.
  always @(posedge clk) begin
    bit o_evt, u_evt;
    o_evt = 1'b0;
    u_evt = 1'b0;
    if (reset) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      model_valid = 1'b1;
    end else begin
      if (in_push_en && in_pop_en) begin
        if (q.size() == 0) q.push_back(in_data);
        else q[q.size()-1] = in_data;
      end else if (in_push_en) begin
        if (q.size() < DEPTH) q.push_back(in_data);
        else o_evt = 1'b1;
      end else if (in_pop_en) begin
        if (q.size() > 0) void'(q.pop_back());
        else u_evt = 1'b1;
      end
      if (ERR_EN) begin
        m_ovf = o_evt ? 1'b1 : (in_clear_err ? 1'b0 : m_ovf);
        m_udf = u_evt ? 1'b1 : (in_clear_err ? 1'b0 : m_udf);
      end
    end
  end

  // Compare process: DUT outputs vs model every cycle after the first reset.
  always @(negedge clk) begin
    logic [WIDTH-1:0] e_data;
    logic [4:0] e_cnt;
    logic [3:0] e_flg;
    if (model_valid) begin
      e_data = (q.size() == 0) ? '0 : q[q.size()-1];
      e_cnt  = 5'(q.size());
      e_flg  = {m_udf, m_ovf, (q.size() == DEPTH), (q.size() == 0)};
      checks++;
      if (out_data !== e_data || out_count !== e_cnt || out_flags !== e_flg) begin
        failures++;
        $display("FAIL model t=%0t data=%h/%h count=%0d/%0d flags=%b/%b (actual/required)",
                 $time, out_data, e_data, out_count, e_cnt, out_flags, e_flg);
      end
    end
  end

  task automatic step(input bit rst, input bit push, input bit pop, input bit clr,
                      input logic [WIDTH-1:0] d);
    reset = rst; in_push_en = push; in_pop_en = pop; in_clear_err = clr; in_data = d;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; in_push_en = 1'b0; in_pop_en = 1'b0; in_clear_err = 1'b0;
  endtask

  task automatic expect_lit(input string name, input logic [WIDTH-1:0] d,
                            input logic [4:0] c, input logic [3:0] f);
    checks++;
    if (out_data !== d || out_count !== c || out_flags !== f) begin
      failures++;
      $display("FAIL %s data=%h/%h count=%0d/%0d flags=%b/%b (actual/required)",
               name, out_data, d, out_count, c, out_flags, f);
    end
  endtask

  initial begin
    int pct;
    @(negedge clk);
    step(1, 0, 0, 0, '0);
    expect_lit("reset", 9'h000, 5'd0, 4'b0001);

    step(0, 1, 0, 0, 9'h1E1);
    expect_lit("push1", 9'h1E1, 5'd1, 4'b0000);
    step(0, 1, 0, 0, 9'h005);
    expect_lit("push2", 9'h005, 5'd2, 4'b0000);
    step(0, 0, 1, 0, '0);
    expect_lit("pop1", 9'h1E1, 5'd1, 4'b0000);
    step(0, 0, 1, 0, '0);
    expect_lit("pop2", 9'h000, 5'd0, 4'b0001);

    for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 9'(9'h100 + i));
    expect_lit("fill", 9'h10F, 5'd16, 4'b0010);
    step(0, 1, 0, 0, 9'h1FF);
    expect_lit("overflow", 9'h10F, 5'd16, ERR_EN ? 4'b0110 : 4'b0010);
    step(0, 1, 1, 0, 9'h0F0);
    expect_lit("replace_full", 9'h0F0, 5'd16, ERR_EN ? 4'b0110 : 4'b0010);

    step(1, 0, 0, 0, '0);
    step(0, 0, 1, 0, '0);
    expect_lit("underflow", 9'h000, 5'd0, ERR_EN ? 4'b1001 : 4'b0001);
    step(0, 0, 1, 1, '0);
    expect_lit("clear_vs_new", 9'h000, 5'd0, ERR_EN ? 4'b1001 : 4'b0001);
    step(0, 0, 0, 1, '0);
    expect_lit("clear", 9'h000, 5'd0, 4'b0001);

    step(0, 1, 0, 0, 9'h011);
    step(0, 1, 0, 0, 9'h022);
    step(0, 1, 0, 0, 9'h0AA);
    expect_lit("pre_replace", 9'h0AA, 5'd3, 4'b0000);
    step(0, 1, 1, 0, 9'h155);
    expect_lit("replace", 9'h155, 5'd3, 4'b0000);
    step(0, 0, 1, 0, '0);
    expect_lit("pop_after_replace", 9'h022, 5'd2, 4'b0000);

    step(1, 0, 0, 0, '0);
    step(0, 1, 1, 0, 9'h033);
    expect_lit("pushpop_empty", 9'h033, 5'd1, 4'b0000);

    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 9'(9'h040 + i));
    expect_lit("five", 9'h043, 5'd5, 4'b0000);
    step(1, 1, 0, 0, 9'h077);
    expect_lit("reset_mid", 9'h000, 5'd0, 4'b0001);

    // Randomized phases with varying push bias to sweep empty and full.
    for (int i = 0; i < 3000; i++) begin
      case ((i / 200) % 3)
        0: pct = 75;
        1: pct = 25;
        default: pct = 50;
      endcase
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 99) < pct),
           ($urandom_range(0, 99) < 100 - pct),
           ($urandom_range(0, 19) == 0),
           WIDTH'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/call_stack.md
# call_stack

Hardware return-address stack that serves the control unit's call-subroutine and return-subroutine instructions. It responds to the control unit's push/pop strobes by storing or releasing 9-bit PC values. It presents the current top-of-stack and a 4-bit flag vector back to the control unit. It sits beside the PC, fed by the PC output and feeding the PC load input.

## Interface
- `DEPTH`, default 16: number of entries; must be a power of two, at least 2.
- `WIDTH`, default 9: entry width, matching the PC width.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  reset, synchronous and active-high.
- `in_push_en`  in  1  push `in_data` this cycle.
- `in_pop_en`  in  1  pop the top entry this cycle.
- `in_clear_err`  in  1  clear the sticky error flags.
- `in_data`  in  WIDTH  value to push; normally the PC of the instruction after the call.
- `out_data`  out  WIDTH  current top-of-stack; 0 when the stack is empty.
- `out_flags`  out  4  {underflow, overflow, full, empty}; bit 0 is empty.
- `out_count`  out  $clog2(DEPTH)+1  number of valid entries.

## Operation
- Storage is an array of `DEPTH` x `WIDTH` entries plus a stack pointer `sp`, where `sp` = `out_count`, range 0..DEPTH.
- **Push only:**
  - If not full: write `in_data` to `mem[sp]` and set `sp` to `sp+1`.
  - If full: ignore the push; `mem` and `sp` are unchanged; set overflow (see Configuration).
- **Pop only:**
  - If not empty: set `sp` to `sp-1`.
  - If empty: ignore the pop; `sp` stays 0; set underflow.
  - Popped entries are not erased.
- **Push and pop together:**
  - Non-empty: replace the top entry with `in_data`; `sp` is unchanged.
  - Empty: behave as a plain push; no underflow.
  - Full: replace the top entry; no overflow.
- **Neither strobe:** hold all state.
- **Flags:**
  - empty = (`sp` == 0)
  - full = (`sp` == DEPTH)
  - overflow and underflow are sticky. They are cleared by `reset` or by `in_clear_err`.
  - When `in_clear_err` coincides with a new error, the new error wins: the flag is set.
- **Top-of-stack output:** `out_data` is registered and always equals `mem[sp-1]` after each edge, or 0 when `sp` is 0. Every push, pop or replace updates it for the next cycle.
- The control unit therefore samples `out_data` in the same cycle it asserts `in_pop_en`. It loads the PC from that value.

## Timing
- **Reset** (on the clock edge where `reset`=1):
  - `sp`=0, `out_data`=0, `out_flags`=4'b0001, `out_count`=0.
  - Memory contents are not cleared.
  - `reset` overrides any concurrent push or pop.
- **Latency:** one cycle from a strobe to updated `out_data`, `out_count` and `out_flags`.
- A push at edge k makes the pushed value visible on `out_data` after edge k.
- Back-to-back strobes on consecutive cycles are legal, with one operation per cycle and no stall.
- Strobes are level-sampled on each rising edge. A strobe held for N cycles performs N operations.
- Reset mid-sequence discards all entries. The next pop after reset underflows.

## Configuration
- The macro `CALL_STACK_ERROR_FLAGS_EN` controls the error flags.
- **Defined:**
  - Sticky overflow (bit 2) and underflow (bit 3) are implemented as described.
  - `in_clear_err` is functional.
- **Undefined:**
  - Bits 3:2 of `out_flags` are tied to 0.
  - `in_clear_err` is ignored.
  - Ignored pushes and pops still leave state unchanged.
  - Empty and full flags behave identically to the defined case.

## Test plan
- **Reset state:** assert `reset` for 1 cycle → `out_flags`=4'b0001, `out_count`=0, `out_data`=0.
- **Push then pop:** push 9'h1E1, then push 9'h005.
  - After pushing 9'h1E1: `out_data`=9'h1E1.
  - After pushing 9'h005: `out_data`=9'h005, `out_count`=2.
  - Pop → `out_data`=9'h1E1, `out_count`=1.
  - Pop → `out_data`=0, `out_flags`=4'b0001.
- **Fill and overflow:** push 16 values 9'h100..9'h10F → `out_flags`=4'b0010, `out_data`=9'h10F.
  - A 17th push of 9'h1FF → `out_data` stays 9'h10F, `out_count`=16, `out_flags`=4'b0110 (macro defined) or 4'b0010 (macro undefined).
- **Underflow and clear:** pop on an empty stack → `out_flags`=4'b1001 and `out_count`=0.
  - Then pulse `in_clear_err` → `out_flags`=4'b0001.
- **Simultaneous push and pop:** with 9'h0AA on top and `out_count`=3, assert push 9'h155 with pop → `out_data`=9'h155, `out_count`=3.
  - Same on an empty stack with 9'h033 → `out_data`=9'h033, `out_count`=1, underflow not set.
- **Reset mid-operation:** with 5 entries, assert `reset` together with a push of 9'h077 → `out_count`=0, `out_data`=0, `out_flags`=4'b0001.
